// File: rtl/spi_pkg.sv
// Shared constants, state encoding and SPI mode decode for the SPI peripheral.
package spi_pkg;

   localparam int SPI_BITS_PER_BYTE = 8;
   localparam logic [SPI_BITS_PER_BYTE-1:0] SPI_UNDERRUN_BYTE = 8'h00;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

   function automatic logic spi_cpol(input int mode);
      return (mode == 2) || (mode == 3);
   endfunction

   function automatic logic spi_cpha(input int mode);
      return (mode == 1) || (mode == 3);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_D,
   output logic o_Q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_sync <= {STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_D};
      end
   end

   assign o_Q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral: SCK/CS_n/MOSI oversampled into i_Clk, byte-wide RX strobe and TX holding register.
// state     | meaning
// ST_IDLE   | CS_n inactive, MISO driven 0, waiting for CS_n to fall
// ST_ACTIVE | CS_n active, sampling MOSI and shifting MISO on SCK edges
module spi_slave
   import spi_pkg::*;
#(
   parameter int SPI_MODE    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_TX_Underrun,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   input  logic       i_SPI_Clk,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_SPI_MISO,
   output logic       o_SPI_MISO_En
);

   localparam logic CPOL = spi_cpol(SPI_MODE);
   localparam logic CPHA = spi_cpha(SPI_MODE);
   localparam int   CW   = $clog2(SPI_BITS_PER_BYTE);
   localparam logic [CW-1:0] CNT_TOP = CW'(SPI_BITS_PER_BYTE - 1);

   logic w_sck_s, w_cs_n_s, w_mosi_s;
   logic r_sck_d;
   logic w_lead, w_trail, w_sample, w_shift;
   logic w_entry, w_live, w_load;
   logic [7:0] w_load_byte, w_rx_merged;

   spi_state_t r_state;
   logic [CW-1:0] r_rx_cnt;
   logic [7:0] r_rx_shift, r_rx_byte, r_tx_shift, r_hold;
   logic r_rx_dv, r_miso, r_miso_en, r_slot_pend, r_hold_full, r_underrun;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_Clk), .o_Q(w_sck_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_CS_n), .o_Q(w_cs_n_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_D(i_SPI_MOSI), .o_Q(w_mosi_s));

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_sck_d <= CPOL;
      end else begin
         r_sck_d <= w_sck_s;
      end
   end

   assign w_lead   = CPOL ? (!w_sck_s && r_sck_d) : (w_sck_s && !r_sck_d);
   assign w_trail  = CPOL ? (w_sck_s && !r_sck_d) : (!w_sck_s && r_sck_d);
   assign w_sample = CPHA ? w_trail : w_lead;
   assign w_shift  = CPHA ? w_lead  : w_trail;

   assign w_entry = (r_state == ST_IDLE) && !w_cs_n_s;
   assign w_live  = (r_state == ST_ACTIVE) && !w_cs_n_s;
   // A slot starts at CS entry only for CPHA=0; otherwise on the pending shift edge.
   assign w_load      = (w_entry && !CPHA) || (w_live && w_shift && r_slot_pend);
   assign w_load_byte = r_hold_full ? r_hold : SPI_UNDERRUN_BYTE;

   always_comb begin
      w_rx_merged           = r_rx_shift;
      w_rx_merged[r_rx_cnt] = w_mosi_s;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state     <= ST_IDLE;
         r_rx_cnt    <= CNT_TOP;
         r_rx_shift  <= '0;
         r_rx_byte   <= '0;
         r_rx_dv     <= 1'b0;
         r_tx_shift  <= '0;
         r_miso      <= 1'b0;
         r_miso_en   <= 1'b0;
         r_slot_pend <= 1'b0;
      end else begin
         r_rx_dv <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_cs_n_s) begin
                  r_state     <= ST_ACTIVE;
                  r_miso_en   <= 1'b1;
                  r_rx_cnt    <= CNT_TOP;
                  r_slot_pend <= CPHA;
                  if (!CPHA) begin
                     r_miso     <= w_load_byte[7];
                     r_tx_shift <= {w_load_byte[6:0], 1'b0};
                  end
               end
            end
            ST_ACTIVE: begin
               if (w_cs_n_s) begin
                  r_state     <= ST_IDLE;
                  r_miso_en   <= 1'b0;
                  r_miso      <= 1'b0;
                  r_rx_cnt    <= CNT_TOP;
                  r_rx_shift  <= '0;
                  r_tx_shift  <= '0;
                  r_slot_pend <= 1'b0;
               end else begin
                  if (w_sample) begin
                     r_rx_shift <= w_rx_merged;
                     r_rx_cnt   <= r_rx_cnt - CW'(1);
                     if (r_rx_cnt == '0) begin
                        r_rx_byte   <= w_rx_merged;
                        r_rx_dv     <= 1'b1;
                        r_slot_pend <= 1'b1;
                     end
                  end
                  // r_tx_shift holds the bits not yet presented, MSB next.
                  if (w_shift) begin
                     if (r_slot_pend) begin
                        r_slot_pend <= 1'b0;
                        r_miso      <= w_load_byte[7];
                        r_tx_shift  <= {w_load_byte[6:0], 1'b0};
                     end else begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A strobe coincident with a load sees the old empty state, so it underruns and is kept for the next slot.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_underrun <= w_load && !r_hold_full;
         if (i_TX_DV && !r_hold_full) begin
            r_hold      <= i_TX_Byte;
            r_hold_full <= 1'b1;
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   assign o_TX_Ready    = !r_hold_full;
   assign o_TX_Underrun = r_underrun;
   assign o_RX_DV       = r_rx_dv;
   assign o_RX_Byte     = r_rx_byte;
   assign o_SPI_MISO    = r_miso;
   assign o_SPI_MISO_En = r_miso_en;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: one spi_slave per SPI mode, each driven by its own behavioural master.
module tb_spi_slave;

   localparam int H = 40;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] sck, cs_n, mosi, tx_dv;
   logic [7:0] tx_byte [4];
   wire  [3:0] miso, miso_en, tx_ready, tx_underrun, rx_dv;
   wire  [7:0] rx_byte [4];

   int n_rx  [4] = '{0, 0, 0, 0};
   int n_und [4] = '{0, 0, 0, 0};
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
         .i_Clk        (clk),
         .i_Rst_L      (rst_n),
         .i_TX_Byte    (tx_byte[g]),
         .i_TX_DV      (tx_dv[g]),
         .o_TX_Ready   (tx_ready[g]),
         .o_TX_Underrun(tx_underrun[g]),
         .o_RX_DV      (rx_dv[g]),
         .o_RX_Byte    (rx_byte[g]),
         .i_SPI_Clk    (sck[g]),
         .i_SPI_CS_n   (cs_n[g]),
         .i_SPI_MOSI   (mosi[g]),
         .o_SPI_MISO   (miso[g]),
         .o_SPI_MISO_En(miso_en[g])
      );
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rx_dv[k] === 1'b1) n_rx[k]++;
         if (tx_underrun[k] === 1'b1) n_und[k]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tx_load(input int m, input logic [7:0] b);
      @(negedge clk);
      tx_byte[m] = b;
      tx_dv[m]   = 1'b1;
      @(negedge clk);
      tx_dv[m]   = 1'b0;
   endtask

   task automatic cs_low(input int m);
      @(negedge clk);
      cs_n[m] = 1'b0;
      #H;
   endtask

   task automatic cs_high(input int m);
      #H;
      cs_n[m] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = (m == 1) || (m == 3);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi[m] = mo[i];
            #H;
            sck[m] = ~cpol;
            mi[i]  = miso[m];
            #H;
            sck[m] = cpol;
         end else begin
            sck[m]  = ~cpol;
            mosi[m] = mo[i];
            #H;
            sck[m] = cpol;
            mi[i]  = miso[m];
            #H;
         end
      end
   endtask

   initial begin
      logic [7:0] mi;
      int r0, u0;

      sck   = 4'b1100;
      cs_n  = 4'hF;
      mosi  = 4'h0;
      tx_dv = 4'h0;
      for (int k = 0; k < 4; k++) tx_byte[k] = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("rst_tx_ready", 32'(tx_ready[k]), 32'd1);
         chk("rst_miso_en", 32'(miso_en[k]), 32'd0);
         chk("rst_rx_byte", 32'(rx_byte[k]), 32'h00);
      end
      chk("rst_miso", 32'(miso), 32'h0);
      chk("rst_dv_und", 32'({rx_dv, tx_underrun}), 32'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // mode 0 single byte; the trailing edge after bit 0 starts an empty slot
      tx_load(0, 8'hA5);
      chk("m0_ready_after_load", 32'(tx_ready[0]), 32'd0);
      r0 = n_rx[0]; u0 = n_und[0];
      cs_low(0);
      chk("m0_miso_en", 32'(miso_en[0]), 32'd1);
      xfer(0, 8'h3C, 8, mi);
      chk("m0_miso_byte", 32'(mi), 32'hA5);
      chk("m0_ready_after_slot", 32'(tx_ready[0]), 32'd1);
      cs_high(0);
      chk("m0_rx_pulses", 32'(n_rx[0] - r0), 32'd1);
      chk("m0_rx_byte", 32'(rx_byte[0]), 32'h3C);
      chk("m0_underruns", 32'(n_und[0] - u0), 32'd1);
      chk("m0_idle_miso_en", 32'(miso_en[0]), 32'd0);
      chk("m0_idle_miso", 32'(miso[0]), 32'd0);

      // mode 3, two bytes under one CS
      tx_load(3, 8'h12);
      r0 = n_rx[3]; u0 = n_und[3];
      cs_low(3);
      xfer(3, 8'hF0, 8, mi);
      chk("m3_miso_b0", 32'(mi), 32'h12);
      chk("m3_rx_b0", 32'(rx_byte[3]), 32'hF0);
      chk("m3_ready_b0", 32'(tx_ready[3]), 32'd1);
      tx_load(3, 8'h34);
      xfer(3, 8'h0F, 8, mi);
      chk("m3_miso_b1", 32'(mi), 32'h34);
      cs_high(3);
      chk("m3_rx_b1", 32'(rx_byte[3]), 32'h0F);
      chk("m3_rx_pulses", 32'(n_rx[3] - r0), 32'd2);
      chk("m3_underruns", 32'(n_und[3] - u0), 32'd0);

      // mode 1, two bytes, nothing preloaded
      r0 = n_rx[1]; u0 = n_und[1];
      cs_low(1);
      xfer(1, 8'h96, 8, mi);
      chk("m1_miso_b0", 32'(mi), 32'h00);
      chk("m1_rx_b0", 32'(rx_byte[1]), 32'h96);
      xfer(1, 8'h4B, 8, mi);
      chk("m1_miso_b1", 32'(mi), 32'h00);
      cs_high(1);
      chk("m1_rx_b1", 32'(rx_byte[1]), 32'h4B);
      chk("m1_rx_pulses", 32'(n_rx[1] - r0), 32'd2);
      chk("m1_underruns", 32'(n_und[1] - u0), 32'd2);

      // mode 2, one byte, nothing preloaded: entry slot plus the slot after bit 0
      r0 = n_rx[2]; u0 = n_und[2];
      cs_low(2);
      xfer(2, 8'h69, 8, mi);
      chk("m2_miso", 32'(mi), 32'h00);
      cs_high(2);
      chk("m2_rx_byte", 32'(rx_byte[2]), 32'h69);
      chk("m2_rx_pulses", 32'(n_rx[2] - r0), 32'd1);
      chk("m2_underruns", 32'(n_und[2] - u0), 32'd2);

      // mode 0 abort after 4 bits, then a full byte
      tx_load(0, 8'hE7);
      r0 = n_rx[0];
      cs_low(0);
      tx_load(0, 8'h5B);
      xfer(0, 8'hC3, 4, mi);
      chk("abort_miso_nibble", 32'(mi[7:4]), 32'hE);
      cs_high(0);
      chk("abort_no_rx", 32'(n_rx[0] - r0), 32'd0);
      chk("abort_rx_byte_kept", 32'(rx_byte[0]), 32'h3C);
      chk("abort_hold_kept", 32'(tx_ready[0]), 32'd0);
      u0 = n_und[0];
      cs_low(0);
      xfer(0, 8'h5A, 8, mi);
      chk("after_abort_miso", 32'(mi), 32'h5B);
      cs_high(0);
      chk("after_abort_rx", 32'(rx_byte[0]), 32'h5A);
      chk("after_abort_pulses", 32'(n_rx[0] - r0), 32'd1);
      chk("after_abort_und", 32'(n_und[0] - u0), 32'd1);

      // mode 0 strobe while full is ignored
      tx_load(0, 8'h11);
      tx_load(0, 8'h22);
      chk("full_ready", 32'(tx_ready[0]), 32'd0);
      cs_low(0);
      xfer(0, 8'h81, 8, mi);
      chk("full_miso", 32'(mi), 32'h11);
      cs_high(0);
      chk("full_rx", 32'(rx_byte[0]), 32'h81);

      // mode 0 strobe in the same cycle as the entry load
      u0 = n_und[0];
      @(negedge clk);
      cs_n[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tx_byte[0] = 8'h44;
      tx_dv[0]   = 1'b1;
      @(negedge clk);
      tx_dv[0]   = 1'b0;
      #H;
      xfer(0, 8'hC0, 8, mi);
      chk("coinc_miso_b0", 32'(mi), 32'h00);
      chk("coinc_und_b0", 32'(n_und[0] - u0), 32'd1);
      xfer(0, 8'h03, 8, mi);
      chk("coinc_miso_b1", 32'(mi), 32'h44);
      cs_high(0);
      chk("coinc_rx_b1", 32'(rx_byte[0]), 32'h03);

      // mode 1 reset in the middle of a byte
      tx_load(1, 8'hAB);
      cs_low(1);
      xfer(1, 8'hFF, 3, mi);
      tx_load(1, 8'hCD);
      chk("pre_rst_miso", 32'(miso[1]), 32'd1);
      chk("pre_rst_miso_en", 32'(miso_en[1]), 32'd1);
      chk("pre_rst_ready", 32'(tx_ready[1]), 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_miso", 32'(miso[1]), 32'd0);
      chk("rst_mid_miso_en", 32'(miso_en[1]), 32'd0);
      chk("rst_mid_ready", 32'(tx_ready[1]), 32'd1);
      chk("rst_mid_rx_byte", 32'(rx_byte[1]), 32'h00);
      chk("rst_mid_dv_und", 32'({rx_dv[1], tx_underrun[1]}), 32'd0);
      cs_n[1] = 1'b1;
      #20;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      r0 = n_rx[1];
      cs_low(1);
      xfer(1, 8'hC5, 8, mi);
      chk("post_rst_miso", 32'(mi), 32'h00);
      cs_high(1);
      chk("post_rst_rx", 32'(rx_byte[1]), 32'hC5);
      chk("post_rst_pulses", 32'(n_rx[1] - r0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
